// File: rtl/running_max_if.sv
// running_max_if
//   Bundles the score/V stream into running_max and the max-annotated
//   stream out of it towards expmul.
//   slave  : the running_max side (consumes vld_in/s_in/v_in, drives outputs)
//   master : the upstream/downstream side (testbench or neighbouring blocks)
//   Optional macro RUNMAX_DELTA_EN adds delta_out (m_prev - m_new).
// Parameters: DATA_W (score width), V_W (V vector width), ROW_W (row index width)
interface running_max_if #(
    parameter int DATA_W = 16,
    parameter int V_W    = 32,
    parameter int ROW_W  = 4
);
    logic                     vld_in;
    logic                     rdy_out;
    logic signed [DATA_W-1:0] s_in;
    logic [V_W-1:0]           v_in;
    logic                     vld_out;
    logic                     rdy_in;
    logic signed [DATA_W-1:0] a_out;
    logic signed [DATA_W-1:0] b_out;
    logic signed [DATA_W-1:0] m_prev_out;
    logic [V_W-1:0]           v_out;
    logic                     first_out;
    logic                     last_out;
    logic [ROW_W-1:0]         row_idx_out;
`ifdef RUNMAX_DELTA_EN
    logic signed [DATA_W-1:0] delta_out;
`endif

    modport slave (
        input  vld_in, s_in, v_in, rdy_in,
        output rdy_out, vld_out, a_out, b_out, m_prev_out, v_out,
`ifdef RUNMAX_DELTA_EN
        output delta_out,
`endif
        output first_out, last_out, row_idx_out
    );

    modport master (
        output vld_in, s_in, v_in, rdy_in,
        input  rdy_out, vld_out, a_out, b_out, m_prev_out, v_out,
`ifdef RUNMAX_DELTA_EN
        input  delta_out,
`endif
        input  first_out, last_out, row_idx_out
    );
endinterface

// File: rtl/running_max.sv
// running_max
//   Online-softmax running-maximum stage ahead of expmul. Each accepted
//   (score, V) beat is annotated with the row maximum before and after the
//   score, key/row position flags, and is queued in a main+skid buffer so
//   that rdy_out is a pure register output (no path from rdy_in).
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-low reset
//   bus  - running_max_if.slave: vld_in/rdy_out/s_in/v_in upstream,
//          vld_out/rdy_in/a_out/b_out/m_prev_out/v_out/first_out/last_out/
//          row_idx_out downstream
// Optional feature: define RUNMAX_DELTA_EN to add delta_out = m_prev - m_new,
//   saturated to the most negative score value.
module running_max #(
    parameter int DATA_W   = 16,
    parameter int V_W      = 32,
    parameter int NUM_KEYS = 16,
    parameter int NUM_ROWS = 16
) (
    input  logic         clk,
    input  logic         rst,
    running_max_if.slave bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef enum logic {FIRST = 1'b0, ACCUM = 1'b1} state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic signed [DATA_W-1:0] m_prev;
`ifdef RUNMAX_DELTA_EN
        logic signed [DATA_W-1:0] delta;
`endif
        logic [V_W-1:0]           v;
        logic                     first;
        logic                     last;
        logic [ROW_W-1:0]         row;
    } rec_t;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        return (x > y) ? x : y;
    endfunction

`ifdef RUNMAX_DELTA_EN
    // m_prev <= m_new always, so only the negative bound can be exceeded.
    function automatic logic signed [DATA_W-1:0] sat_delta(
        input logic signed [DATA_W-1:0] prev,
        input logic signed [DATA_W-1:0] nw
    );
        logic signed [DATA_W:0] w;
        w = $signed({prev[DATA_W-1], prev}) - $signed({nw[DATA_W-1], nw});
        if (w[DATA_W] != w[DATA_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        return w[DATA_W-1:0];
    endfunction
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [KEY_W-1:0]         r_key_cnt;
    logic [ROW_W-1:0]         r_row_cnt;
    logic signed [DATA_W-1:0] r_m_reg;
    logic signed [DATA_W-1:0] w_m_new;
    logic signed [DATA_W-1:0] w_m_prev;
    logic                     w_acc;
    logic                     w_xfer;
    logic                     w_last_key;
    rec_t                     w_rec;
    rec_t                     r_main_p1;
    rec_t                     r_skid_p1;
    logic                     r_vld_p1;
    logic                     r_skid_vld_p1;

    assign w_acc      = bus.vld_in & bus.rdy_out;
    assign w_xfer     = r_vld_p1 & bus.rdy_in;
    assign w_last_key = (r_key_cnt == LAST_KEY);

    // ---- stage p0: FSM, running max and record assembly ----
    always_ff @(posedge clk) begin
        if (!rst) r_state <= FIRST;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_prev    = bus.s_in;
        w_m_new     = bus.s_in;
        if (r_state == ACCUM) begin
            w_m_prev = r_m_reg;
            w_m_new  = smax(r_m_reg, bus.s_in);
        end
        if (w_acc) begin
            if (w_last_key) w_state_nxt = FIRST;
            else            w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_key_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_acc) begin
            if (w_last_key) begin
                r_key_cnt <= '0;
                r_row_cnt <= (r_row_cnt == LAST_ROW) ? '0 : r_row_cnt + ROW_W'(1);
            end else begin
                r_key_cnt <= r_key_cnt + KEY_W'(1);
            end
        end
    end

    // In FIRST the register is simply overwritten, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_acc) r_m_reg <= w_m_new;
    end

    always_comb begin
        w_rec        = '0;
        w_rec.a      = bus.s_in;
        w_rec.b      = w_m_new;
        w_rec.m_prev = w_m_prev;
`ifdef RUNMAX_DELTA_EN
        w_rec.delta  = sat_delta(w_m_prev, w_m_new);
`endif
        w_rec.v      = bus.v_in;
        w_rec.first  = (r_key_cnt == '0);
        w_rec.last   = w_last_key;
        w_rec.row    = r_row_cnt;
    end

    // ---- stage p1: main + skid output buffer ----
    // Upstream can only be accepted while the skid is empty, so an accept
    // never coincides with a valid skid entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_main_p1     <= '0;
        end else if (r_skid_vld_p1) begin
            if (w_xfer) begin
                r_main_p1     <= r_skid_p1;
                r_skid_vld_p1 <= 1'b0;
            end
        end else if (w_acc) begin
            if (!r_vld_p1 || w_xfer) begin
                r_main_p1 <= w_rec;
                r_vld_p1  <= 1'b1;
            end else begin
                r_skid_p1     <= w_rec;
                r_skid_vld_p1 <= 1'b1;
            end
        end else if (w_xfer) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.rdy_out     = rst & ~r_skid_vld_p1;
    assign bus.vld_out     = r_vld_p1;
    assign bus.a_out       = r_main_p1.a;
    assign bus.b_out       = r_main_p1.b;
    assign bus.m_prev_out  = r_main_p1.m_prev;
    assign bus.v_out       = r_main_p1.v;
    assign bus.first_out   = r_main_p1.first;
    assign bus.last_out    = r_main_p1.last;
    assign bus.row_idx_out = r_main_p1.row;
`ifdef RUNMAX_DELTA_EN
    assign bus.delta_out   = r_main_p1.delta;
`endif
endmodule

// File: tb/tb_running_max.sv
module tb_running_max;
    localparam int DW   = 8;
    localparam int VW   = 16;
    localparam int NK_A = 4;
    localparam int NR_A = 16;

    logic clk = 1'b0;
    logic rsta = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    running_max_if #(.DATA_W(DW), .V_W(VW), .ROW_W(4)) ifa ();
    running_max_if #(.DATA_W(DW), .V_W(VW), .ROW_W(2)) ifb ();

    running_max #(.DATA_W(DW), .V_W(VW), .NUM_KEYS(NK_A), .NUM_ROWS(NR_A)) dut_a (
        .clk(clk), .rst(rsta), .bus(ifa));
    running_max #(.DATA_W(DW), .V_W(VW), .NUM_KEYS(2), .NUM_ROWS(3)) dut_b (
        .clk(clk), .rst(rstb), .bus(ifb));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic signed [7:0] s;
        logic signed [7:0] b;
        logic signed [7:0] mp;
        bit                first;
        bit                last;
        int                row;
        logic signed [7:0] d;
    } vec_t;

    vec_t tab_a[4];
    vec_t tab_b[8];

    // ---------------- behavioural model ----------------
    typedef struct {
        logic signed [7:0] a, b, mp, d;
        logic [15:0]       v;
        bit                first, last;
        int                row;
    } rec_t;

    rec_t expq[$];
    int   row_s[$];
    int   n_acc = 0;

    // Row maximum computed over the list of scores seen so far in the row.
    task automatic model_accept(input int s, input logic [15:0] v);
        rec_t r;
        int key, mx, pm, d;
        key = n_acc % NK_A;
        if (key == 0) row_s.delete();
        pm = s;
        if (key != 0) begin
            pm = row_s[0];
            foreach (row_s[i]) if (row_s[i] > pm) pm = row_s[i];
        end
        row_s.push_back(s);
        mx = row_s[0];
        foreach (row_s[i]) if (row_s[i] > mx) mx = row_s[i];
        d = pm - mx;
        if (d < -128) d = -128;
        r.a = 8'(s); r.b = 8'(mx); r.mp = 8'(pm); r.d = 8'(d);
        r.v = v;
        r.first = (key == 0);
        r.last  = (key == NK_A - 1);
        r.row   = (n_acc / NK_A) % NR_A;
        expq.push_back(r);
        n_acc++;
    endtask

    // One clock of DUT A: checks occupancy-derived flags, scores any
    // transfer against the model, records any accept, then advances.
    task automatic step_a(input bit vin, input logic signed [7:0] s, input logic [15:0] v,
                          input bit rin, output bit acc);
        rec_t e;
        chk("vld_out_occ", ifa.vld_out, expq.size() != 0);
        chk("rdy_out_occ", ifa.rdy_out, expq.size() < 2);
        ifa.vld_in = vin; ifa.s_in = s; ifa.v_in = v; ifa.rdy_in = rin;
        if (ifa.vld_out && rin && expq.size() != 0) begin
            e = expq.pop_front();
            chk("tag",    ifa.v_out, e.v);
            chk("a_out",  ifa.a_out, e.a);
            chk("b_out",  ifa.b_out, e.b);
            chk("m_prev", ifa.m_prev_out, e.mp);
            chk("first",  ifa.first_out, e.first);
            chk("last",   ifa.last_out, e.last);
            chk("row",    ifa.row_idx_out, e.row);
`ifdef RUNMAX_DELTA_EN
            chk("delta",  ifa.delta_out, e.d);
`endif
        end
        acc = vin && ifa.rdy_out;
        if (acc) model_accept(s, v);
        @(posedge clk); #1;
    endtask

    task automatic do_reset_a();
        ifa.vld_in = 0; ifa.rdy_in = 0; ifa.s_in = 0; ifa.v_in = 0;
        rsta = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_vld_out", ifa.vld_out, 0);
        chk("rst_rdy_out", ifa.rdy_out, 0);
        chk("rst_a_out",   ifa.a_out, 0);
        chk("rst_b_out",   ifa.b_out, 0);
        chk("rst_m_prev",  ifa.m_prev_out, 0);
        chk("rst_first",   ifa.first_out, 0);
        chk("rst_last",    ifa.last_out, 0);
        chk("rst_row",     ifa.row_idx_out, 0);
        rsta = 1;
        @(posedge clk); #1;
        expq.delete(); row_s.delete(); n_acc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc, pend;
        logic signed [7:0] ps, d;
        logic [15:0] pv;
        int tag, nsent;

        tab_a[0] = '{ 3,  3,  3, 1, 0, 0,  0};
        tab_a[1] = '{-2,  3,  3, 0, 0, 0,  0};
        tab_a[2] = '{ 7,  7,  3, 0, 0, 0, -4};
        tab_a[3] = '{ 7,  7,  7, 0, 1, 0,  0};
        tab_b[0] = '{ 5,  5,  5, 1, 0, 0,  0};
        tab_b[1] = '{ 1,  5,  5, 0, 1, 0,  0};
        tab_b[2] = '{-4, -4, -4, 1, 0, 1,  0};
        tab_b[3] = '{-9, -4, -4, 0, 1, 1,  0};
        tab_b[4] = '{ 3,  3,  3, 1, 0, 2,  0};
        tab_b[5] = '{ 8,  8,  3, 0, 1, 2, -5};
        tab_b[6] = '{-1, -1, -1, 1, 0, 0,  0};
        tab_b[7] = '{-1, -1, -1, 0, 1, 0,  0};
        ifb.vld_in = 0; ifb.rdy_in = 0; ifb.s_in = 0; ifb.v_in = 0;

        // Reset state and basic max tracking, one-cycle latency
        do_reset_a();
        for (int i = 0; i < 4; i++) begin
            ifa.vld_in = 1; ifa.s_in = tab_a[i].s; ifa.v_in = 16'(i); ifa.rdy_in = 1;
            @(posedge clk); #1;
`ifdef RUNMAX_DELTA_EN
            d = ifa.delta_out;
`else
            d = tab_a[i].d;
`endif
            chk("basic_vld",   ifa.vld_out, 1);
            chk("basic_a",     ifa.a_out, tab_a[i].s);
            chk("basic_b",     ifa.b_out, tab_a[i].b);
            chk("basic_mprev", ifa.m_prev_out, tab_a[i].mp);
            chk("basic_first", ifa.first_out, tab_a[i].first);
            chk("basic_last",  ifa.last_out, tab_a[i].last);
            chk("basic_row",   ifa.row_idx_out, tab_a[i].row);
            chk("basic_delta", d, tab_a[i].d);
        end
        ifa.vld_in = 0;

        // Row wrap on the NUM_KEYS=2, NUM_ROWS=3 instance
        rstb = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b_rst_vld", ifb.vld_out, 0);
        rstb = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            ifb.vld_in = 1; ifb.s_in = tab_b[i].s; ifb.v_in = 16'(i); ifb.rdy_in = 1;
            @(posedge clk); #1;
`ifdef RUNMAX_DELTA_EN
            d = ifb.delta_out;
`else
            d = tab_b[i].d;
`endif
            chk("wrap_vld",   ifb.vld_out, 1);
            chk("wrap_b",     ifb.b_out, tab_b[i].b);
            chk("wrap_mprev", ifb.m_prev_out, tab_b[i].mp);
            chk("wrap_first", ifb.first_out, tab_b[i].first);
            chk("wrap_last",  ifb.last_out, tab_b[i].last);
            chk("wrap_row",   ifb.row_idx_out, tab_b[i].row);
            chk("wrap_delta", d, tab_b[i].d);
        end
        ifb.vld_in = 0;

        // Backpressure: continuous upstream, rdy_in low for 3 cycles
        do_reset_a();
        pend = 0; nsent = 0; tag = 200;
        for (int i = 0; i < 16; i++) begin
            if (!pend && nsent < 10) begin
                pend = 1; ps = 8'(nsent * 3 - 10); pv = 16'(tag); tag++; nsent++;
            end
            step_a(pend, ps, pv, i >= 3, acc);
            if (acc) pend = 0;
            if (i == 0) chk("bp_rdy_hold", ifa.rdy_out, 1);
            if (i == 1) chk("bp_rdy_drop", ifa.rdy_out, 0);
        end
        chk("bp_drained", expq.size(), 0);

        // Simultaneous accept/transfer with the skid full
        do_reset_a();
        pend = 0; nsent = 0; tag = 300;
        for (int i = 0; i < 12; i++) begin
            if (!pend && nsent < 6) begin
                pend = 1; ps = 8'(20 - nsent * 7); pv = 16'(tag); tag++; nsent++;
            end
            step_a(pend, ps, pv, i != 1, acc);
            if (acc) pend = 0;
            if (i == 1) chk("sim_rdy_drop", ifa.rdy_out, 0);
            if (i == 2) chk("sim_rdy_back", ifa.rdy_out, 1);
        end
        chk("sim_drained", expq.size(), 0);

        // Saturation of delta: INT_T min then INT_T max in one row
        do_reset_a();
        step_a(1, -8'sd128, 16'd400, 1, acc);
        step_a(1, 8'sd127, 16'd401, 1, acc);
        chk("sat_b", ifa.b_out, 127);
`ifdef RUNMAX_DELTA_EN
        chk("sat_delta", ifa.delta_out, -128);
`endif
        step_a(0, 0, 0, 1, acc);
        step_a(0, 0, 0, 1, acc);

        // Reset mid-row discards the partial row
        do_reset_a();
        step_a(1, 8'sd10, 16'd500, 1, acc);
        step_a(1, 8'sd2, 16'd501, 1, acc);
        do_reset_a();
        step_a(1, -8'sd6, 16'd502, 1, acc);
        chk("mid_vld",   ifa.vld_out, 1);
        chk("mid_first", ifa.first_out, 1);
        chk("mid_b",     ifa.b_out, -6);
        chk("mid_mprev", ifa.m_prev_out, -6);
        chk("mid_row",   ifa.row_idx_out, 0);
        step_a(0, 0, 0, 1, acc);

        // Randomized traffic against the model
        do_reset_a();
        pend = 0; tag = 1000;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1; ps = 8'($urandom_range(0, 255)); pv = 16'(tag); tag++;
            end
            step_a(pend, ps, pv, $urandom_range(0, 9) < 7, acc);
            if (acc) pend = 0;
        end
        for (int i = 0; i < 6 && expq.size() != 0; i++) step_a(0, 0, 0, 1, acc);
        chk("rand_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/running_max.md
# running_max

Online-softmax running-maximum stage that sits directly upstream of `expmul` in the attention datapath. It consumes one (score, V-vector) beat per key for the current query row, tracks the running row maximum, and emits a score, a new maximum, a previous maximum and V to `expmul`. `expmul` then forms exp(score − max)·V. The previous maximum drives the accumulator rescale exp(m_prev − m_new). A two-entry skid buffer decouples the upstream ready from downstream backpressure.

## Interface
- NUM_KEYS, 16: keys per query row; must be ≥1.
- NUM_ROWS, 16: query rows per tile; must be ≥1; sets row_idx width = max(1, $clog2(NUM_ROWS)).

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low.
- vld_in  in  1  upstream beat valid.
- rdy_out  out  1  this block can accept a beat.
- s_in  in  INT_T  score (signed two's complement).
- v_in  in  V_VECTOR_T  V vector paired with s_in.
- vld_out  out  1  output beat valid.
- rdy_in  in  1  `expmul` ready.
- a_out  out  INT_T  score, to `expmul` a_in.
- b_out  out  INT_T  running max including this score, to `expmul` b_in.
- m_prev_out  out  INT_T  running max before this score.
- v_out  out  V_VECTOR_T  V passthrough.
- first_out  out  1  beat is key 0 of its row.
- last_out  out  1  beat is key NUM_KEYS−1 of its row.
- row_idx_out  out  row_idx width  row index of the beat.

## Operation
- Accept: the block accepts a beat when vld_in && rdy_out. The output transfers when vld_out && rdy_in.
- FSM has two states, FIRST and ACCUM:
  - FIRST: the next accepted beat starts a row. On accept, m_new = s_in and m_prev = s_in. The FSM moves to ACCUM, or stays in FIRST if NUM_KEYS == 1.
  - ACCUM: on accept, m_prev = m_reg and m_new = signed max(m_reg, s_in).
  - If key_cnt == NUM_KEYS−1 on accept, the FSM returns to FIRST.
- m_reg loads m_new on every accept.
- key_cnt runs 0..NUM_KEYS−1: it increments on accept and wraps to 0 after the last key.
- row_cnt increments on accept of the last key and wraps from NUM_ROWS−1 to 0.
- first_out = (key_cnt == 0) and last_out = (key_cnt == NUM_KEYS−1), both sampled at accept.
- All output fields travel together as one record. Invariant: m_prev_out ≤ b_out, and b_out ≥ a_out.
- Ties (s_in == m_reg): b_out = m_prev_out, so the rescale factor is exactly 1.
- Buffer: one main output register plus one skid register.
  - If the main register holds a beat and is stalled while a beat is accepted, the new beat goes to the skid register.
  - On a downstream transfer, the skid entry moves to the main register.
- Accept and transfer in the same cycle: the record order is preserved and the occupancy is unchanged.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N, when the buffer was empty.
- Throughput: 1 beat/cycle sustained while rdy_in is held high.
- rdy_out = ~skid_full, driven from a register with no combinational path from rdy_in. rdy_out is forced to 0 while rst is low.
- Full: once the skid entry is occupied, rdy_out drops on the next cycle. Accept in the cycle it drops is impossible, and no beat is lost or duplicated.
- Reset (rst low at a posedge) clears:
  - vld_out = 0, both buffer entries invalid, FSM = FIRST, key_cnt = 0, row_cnt = 0.
  - All data outputs = 0, first_out = 0, last_out = 0.
- Reset mid-row: partial-row state is discarded, and the next accepted beat is first_out = 1 with row_idx 0.
- vld_in with rdy_out = 0 has no effect. Upstream must hold its beat until accepted.

## Configuration
- RUNMAX_DELTA_EN defined: adds output port delta_out (INT_T) = m_prev − m_new, which is always ≤ 0.
  - delta_out is computed one bit wider, then saturated to INT_T minimum.
  - It is carried in both buffer entries with the rest of the record.
- RUNMAX_DELTA_EN undefined: the delta_out port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic max tracking. Stimulus: NUM_KEYS=4, scores 3, −2, 7, 7, rdy_in=1. Required response:
  - b_out = 3, 3, 7, 7 and m_prev_out = 3, 3, 3, 7.
  - first_out on beat 0, last_out on beat 3, one cycle latency.
  - With RUNMAX_DELTA_EN, delta_out = 0, 0, −4, 0.
- Backpressure. Stimulus: continuous vld_in, rdy_in low for 3 cycles. Required response:
  - rdy_out falls one cycle after the skid fills.
  - After release, the output sequence exactly equals the input sequence (checked by a V-vector tag), with no gaps beyond the stall.
- Saturation, with RUNMAX_DELTA_EN. Stimulus: row scores INT_T min, then INT_T max. Required response: beat 1 has delta_out = INT_T min (saturated) and b_out = INT_T max.
- Row wrap. Stimulus: NUM_KEYS=2, NUM_ROWS=3, 8 beats. Required response:
  - row_idx_out = 0, 0, 1, 1, 2, 2, 0, 0.
  - The max is reset at each first_out: scores 5, 1, −4, −9 give b_out 5, 5, −4, −4.
- Reset mid-row. Stimulus: NUM_KEYS=4, accept 2 beats (scores 10, 2), rst low for 1 cycle, then score −6. Required response:
  - vld_out = 0 right after reset.
  - The next beat has first_out = 1, b_out = −6, m_prev_out = −6 and row_idx 0.
- Simultaneous accept/transfer with the skid full. Stimulus: drop rdy_in for 1 cycle, then hold it high. Required response: occupancy drains by one per cycle only once vld_in stops, and rdy_out returns to 1 the cycle after the skid empties.
